seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000: cycles each digit is lit (SHOW phase); legal range >= 2.
REQ-002 SHALL have parameter BLANK, default 16: all-off cycles between digits (ghosting guard); legal range >= 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port data_in, input, 32: eight hex nibbles; nibble k = data_in[4k+3:4k] drives digit k.
REQ-006 SHALL have port data_we, input, 1: single-cycle write strobe that loads data_in into the shadow register.
REQ-007 SHALL have port digit_en, input, 8: per-digit enable; 0 forces that digit dark.
REQ-008 SHALL have port dp_in, input, 8: per-digit decimal point request, active-high.
REQ-009 SHALL have port lz_en, input, 1: leading-zero suppression enable.
REQ-010 SHALL have port anode, output, 8: registered digit select, active-low.
REQ-011 SHALL have port seg, output, 7: registered segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port dp, output, 1: registered decimal point, active-low.
REQ-013 SHALL have port frame_start, output, 1: registered one-cycle pulse at the start of digit 0's BLANK phase.

Function
REQ-014 SHALL keep three 32-bit-scale registers: shadow (written by data_we), disp (the value shown) and a phase counter wide enough for max(DIV,BLANK)-1.
REQ-015 SHALL run a two-state FSM, BLANK -> SHOW -> BLANK, with a 3-bit digit index idx.
REQ-016 BLANK SHALL last exactly BLANK cycles with anode=8'hFF, seg=7'h7F and dp=1, then go to SHOW with the counter at 0.
REQ-017 SHOW SHALL last exactly DIV cycles driving digit idx, then go to BLANK with idx <= idx+1 mod 8 (7 wraps to 0).
REQ-018 Digit period SHALL be BLANK+DIV cycles; frame period SHALL be 8*(BLANK+DIV) cycles; there is no idle state.
REQ-019 In SHOW, anode[idx] SHALL be 0 and all other anode bits 1, unless the digit is dark per REQ-021/REQ-022, in which case anode=8'hFF.
REQ-020 seg SHALL be the hex decode of disp nibble idx: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex, 7-bit).
REQ-021 Digit idx SHALL be dark when digit_en[idx]=0, sampled each SHOW cycle.
REQ-022 Digit idx SHALL be dark when lz_en=1, idx!=0, and disp nibbles idx..7 are all zero; digit 0 is never suppressed.
REQ-023 dp SHALL be ~dp_in[idx] in SHOW when the digit is lit, and 1 otherwise; a dark digit shows no dp.
REQ-024 Outputs SHALL be registered and SHALL change on the same edge as the state/idx transition (no extra cycle of latency relative to the FSM).
REQ-025 data_we SHALL load data_in into shadow on the sampling edge; back-to-back strobes SHALL leave the last value written.
REQ-026 disp SHALL update only on the transition 7->0 (entering digit 0 BLANK), loading shadow, so no frame ever mixes old and new digits.
REQ-027 If data_we is asserted on the same edge as the 7->0 transition, disp AND shadow SHALL both load data_in (write-through).
REQ-028 frame_start SHALL be 1 for exactly the first cycle of digit 0's BLANK phase, and SHALL NOT pulse on the cycle after reset release.

Reset
REQ-029 On rst_n=0, asynchronously: state=BLANK, idx=0, counter=0, shadow=0, disp=0, anode=8'hFF, seg=7'h7F, dp=1, frame_start=0.
REQ-030 Reset mid-SHOW SHALL darken the display immediately (same cycle, asynchronously); after release, operation SHALL restart with a full BLANK cycle count for digit 0.
REQ-031 After reset release, disp SHALL remain 0 until the first 7->0 transition; the first frame shows 0 on digit 0, with the other digits blank if lz_en=1.

Verification (DIV=4, BLANK=2)
REQ-032 Scan timing: release reset with digit_en=FF and lz_en=0 -> anode is FF for 2 cycles, then FE for 4, FF for 2, FD for 4, ..., 7F for 4, and the sequence repeats every 48 cycles.
REQ-033 Frame-coherent update: data_we with 32'h89ABCDEF mid-frame -> the current frame is unchanged; the next frame shows digit 0 seg=0E and digit 7 seg=00, and frame_start pulses at the boundary.
REQ-034 Leading-zero suppression: disp=32'h00000120 with lz_en=1 -> digits 3..7 have anode=FF throughout SHOW; digits 0..2 show 40, 24 and 79.
REQ-035 Enable and dp: digit_en=8'hFE and dp_in=8'h02 -> digit 0 is dark; digit 1 shows anode=FD and dp=0; every other digit shows dp=1.
REQ-036 Write-through: data_we with 32'h11111111 on the 7->0 edge -> digit 0 of the new frame shows seg=79.
REQ-037 Reset mid-operation: assert rst_n=0 in digit 5 SHOW -> anode=FF in the same cycle; after release, digit 0 SHOW starts exactly 2 cycles later.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between a host and the eight-digit seven-segment scan controller.
// The host (master) supplies the value, enables and decimal points; the
// controller (slave) drives the multiplexed anode/segment lines and the frame marker.
interface seg7_scan_ctrl_if;
    logic [31:0] data_in;
    logic        data_we;
    logic [7:0]  digit_en;
    logic [7:0]  dp_in;
    logic        lz_en;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (
        output data_in, data_we, digit_en, dp_in, lz_en,
        input  anode, seg, dp, frame_start
    );

    modport slave (
        input  data_in, data_we, digit_en, dp_in, lz_en,
        output anode, seg, dp, frame_start
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner.
// Each digit gets a dark BLANK guard followed by a SHOW window. The displayed
// value only changes at the frame boundary so a frame never mixes two values.
module seg7_scan_ctrl #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        wrap;

    logic [31:0] shadow_q, shadow_d;
    logic [31:0] disp_q, disp_d;

    logic [7:0]  anode_q, anode_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        frame_start_q, frame_start_d;

    logic [31:0] shifted;
    logic        dark;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // State register: phase, cycle counter within the phase, and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: BLANK and SHOW alternate forever; wrap marks digit 7 -> digit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        wrap    = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    wrap    = (idx_q == 3'd7);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow takes every write; disp copies the freshest value only at the frame wrap,
    // so a write landing on the wrap edge goes straight through to the display.
    always_comb begin
        shadow_d = bus.data_we ? bus.data_in : shadow_q;
        disp_d   = wrap ? shadow_d : disp_q;
    end

    // Output decode from the upcoming state so outputs switch on the same edge as the FSM.
    always_comb begin
        shifted       = disp_d >> {idx_d, 2'b00};
        dark          = !bus.digit_en[idx_d] ||
                        (bus.lz_en && (idx_d != 3'd0) && (shifted == 32'd0));
        anode_d       = 8'hFF;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;
        frame_start_d = wrap;
        if (state_d == ST_SHOW) begin
            seg_d = hex_to_seg(shifted[3:0]);
            if (!dark) begin
                anode_d = ~(8'b1 << idx_d);
                dp_d    = ~bus.dp_in[idx_d];
            end
        end
    end

    // Data and output registers; reset forces the display dark immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= 32'd0;
            disp_q        <= 32'd0;
            anode_q       <= 8'hFF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.anode       = anode_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV=4, BLANK=2 (6-cycle digit, 48-cycle frame).
// Expected outputs for each cycle are pushed when that cycle's inputs are driven
// and popped/compared at the following negative edge.
module tb_seg7_scan_ctrl;

    localparam int DIV       = 4;
    localparam int BLANK     = 2;
    localparam int DIGIT_CYC = DIV + BLANK;
    localparam int FRAME_CYC = 8 * DIGIT_CYC;

    typedef struct packed {
        logic [7:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic       frame_start;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_ctrl_if bus_if ();

    seg7_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] shadow_model;
    logic [31:0] disp_model;
    exp_t exp_q[$];

    // Reference hex table, written out independently of the design.
    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Expected outputs in cycle n after reset release, from the frame timeline.
    function automatic exp_t expect_for(input int n);
        int   pos;
        int   d;
        int   ph;
        logic dark;
        exp_t e;
        pos = n % FRAME_CYC;
        d   = pos / DIGIT_CYC;
        ph  = pos % DIGIT_CYC;
        e.anode       = 8'hFF;
        e.seg         = 7'h7F;
        e.dp          = 1'b1;
        e.frame_start = (pos == 0) && (n > 0);
        if (ph >= BLANK) begin
            dark = !bus_if.digit_en[d] ||
                   (bus_if.lz_en && (d != 0) && ((disp_model >> (4 * d)) == 32'd0));
            e.seg = ref_seg(disp_model[4*d +: 4]);
            if (!dark) begin
                e.anode[d] = 1'b0;
                e.dp       = ~bus_if.dp_in[d];
            end
        end
        return e;
    endfunction

    // Pop the expectation for the current cycle and compare every output.
    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty cyc=%0d got=0 exp=1", cyc);
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        checks++;
        assert (bus_if.anode === e.anode) else begin
            failures++;
            $error("FAIL anode cyc=%0d got=%h exp=%h", cyc, bus_if.anode, e.anode);
        end
        checks++;
        assert (bus_if.seg === e.seg) else begin
            failures++;
            $error("FAIL seg cyc=%0d got=%h exp=%h", cyc, bus_if.seg, e.seg);
        end
        checks++;
        assert (bus_if.dp === e.dp) else begin
            failures++;
            $error("FAIL dp cyc=%0d got=%b exp=%b", cyc, bus_if.dp, e.dp);
        end
        checks++;
        assert (bus_if.frame_start === e.frame_start) else begin
            failures++;
            $error("FAIL frame_start cyc=%0d got=%b exp=%b", cyc, bus_if.frame_start, e.frame_start);
        end
    endtask

    // Update the model for the coming edge, push its expectation, clock once, then check.
    task automatic applyStimulus();
        int nxt;
        nxt = cyc + 1;
        if ((nxt % FRAME_CYC) == 0)
            disp_model = bus_if.data_we ? bus_if.data_in : shadow_model;
        if (bus_if.data_we)
            shadow_model = bus_if.data_in;
        exp_q.push_back(expect_for(nxt));
        @(posedge clk);
        #1;
        cyc = nxt;
        bus_if.data_we = 1'b0;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) applyStimulus();
    endtask

    task automatic write_data(input logic [31:0] v);
        bus_if.data_in = v;
        bus_if.data_we = 1'b1;
        applyStimulus();
    endtask

    // Outputs must be fully dark while reset is (or has just been) asserted.
    task automatic check_dark(input string tag);
        checks++;
        assert (bus_if.anode === 8'hFF) else begin
            failures++;
            $error("FAIL %s_anode got=%h exp=ff", tag, bus_if.anode);
        end
        checks++;
        assert (bus_if.seg === 7'h7F) else begin
            failures++;
            $error("FAIL %s_seg got=%h exp=7f", tag, bus_if.seg);
        end
        checks++;
        assert (bus_if.dp === 1'b1) else begin
            failures++;
            $error("FAIL %s_dp got=%b exp=1", tag, bus_if.dp);
        end
        checks++;
        assert (bus_if.frame_start === 1'b0) else begin
            failures++;
            $error("FAIL %s_frame_start got=%b exp=0", tag, bus_if.frame_start);
        end
    endtask

    // Release reset just after an edge and restart the cycle count and model.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        shadow_model = 32'd0;
        disp_model = 32'd0;
        exp_q.delete();
        exp_q.push_back(expect_for(0));
        @(negedge clk);
        checkOutput();
    endtask

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of scan, update, suppression, enable and reset scenarios.
    initial begin
        bus_if.data_in  = 32'd0;
        bus_if.data_we  = 1'b0;
        bus_if.digit_en = 8'hFF;
        bus_if.dp_in    = 8'h00;
        bus_if.lz_en    = 1'b0;
        shadow_model    = 32'd0;
        disp_model      = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_dark("reset");

        $display("[TB] scan timing and frame-coherent update");
        release_reset();
        run_to(17);
        write_data(32'h12345678);
        write_data(32'h89ABCDEF);
        run_to(60);
        write_data(32'h00000120);

        $display("[TB] leading-zero suppression");
        run_to(95);
        bus_if.lz_en = 1'b1;
        run_to(143);

        $display("[TB] digit enable and decimal point");
        bus_if.lz_en    = 1'b0;
        bus_if.digit_en = 8'hFE;
        bus_if.dp_in    = 8'h02;
        run_to(150);
        write_data(32'h22222222);
        run_to(191);

        $display("[TB] write-through on frame wrap");
        bus_if.digit_en = 8'hFF;
        bus_if.dp_in    = 8'h00;
        write_data(32'h11111111);
        run_to(225);

        $display("[TB] asynchronous reset during digit 5 show");
        #2;
        rst_n = 1'b0;
        #1;
        check_dark("async_reset");
        bus_if.lz_en = 1'b1;
        release_reset();
        run_to(52);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
